// File: rtl/sb_hfosc_if.sv
// Oscillator control/status bundle: power-up and enable in, divided clock and ready flag out.
interface sb_hfosc_if;
    logic CLKHFPU;
    logic CLKHFEN;
    logic CLKHF;
    logic CLKHF_RDY;

    modport master (output CLKHFPU, output CLKHFEN, input CLKHF, input CLKHF_RDY);
    modport slave  (input CLKHFPU, input CLKHFEN, output CLKHF, output CLKHF_RDY);
endinterface

// File: rtl/sb_hfosc.sv
// Soft model of the iCE40 HF oscillator: start-up delay, post-divider and glitch-free enable,
// all derived from the master clk with registered outputs.
module sb_hfosc #(
    parameter           CLKHF_DIV      = "0b00",
    parameter int       STARTUP_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    sb_hfosc_if.slave   osc
);
    // Unrecognised divider strings fall back to the fastest setting.
    localparam int H  = (CLKHF_DIV == "0b01") ? 2 :
                        (CLKHF_DIV == "0b10") ? 4 :
                        (CLKHF_DIV == "0b11") ? 8 : 1;
    localparam int CW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam int DW = 3;

    typedef enum logic [1:0] {OFF, STARTUP, RUN} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] div_q, div_d;
    logic          clkhf_q, clkhf_d;
    logic          rdy_q, rdy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        clkhf_d = clkhf_q;
        case (state_q)
            OFF: begin
                cnt_d   = '0;
                div_d   = '0;
                clkhf_d = 1'b0;
                if (osc.CLKHFPU) state_d = STARTUP;
            end
            STARTUP: begin
                div_d   = '0;
                clkhf_d = 1'b0;
                if (cnt_q == CW'(STARTUP_CYCLES - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RUN: begin
                // Gate only while low; a high phase always runs its full length.
                if (!clkhf_q && !osc.CLKHFEN) begin
                    div_d = '0;
                end else if (div_q == DW'(H - 1)) begin
                    clkhf_d = ~clkhf_q;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            default: state_d = OFF;
        endcase
        // Power-down overrides any toggle in the same cycle.
        if (!osc.CLKHFPU) begin
            state_d = OFF;
            cnt_d   = '0;
            div_d   = '0;
            clkhf_d = 1'b0;
        end
        rdy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OFF;
            cnt_q   <= '0;
            div_q   <= '0;
            clkhf_q <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            clkhf_q <= clkhf_d;
            rdy_q   <= rdy_d;
        end
    end

    assign osc.CLKHF     = clkhf_q;
    assign osc.CLKHF_RDY = rdy_q;
endmodule

// File: tb/tb_sb_hfosc.sv
// Drives five oscillators (all divider settings plus an invalid string) from shared random
// PU/EN/rst and compares each against a phase-position reference model every cycle.
module tb_sb_hfosc;
    localparam int SC = 4;
    localparam int N  = 5;

    logic clk = 1'b0;
    logic rst, pu, en;
    logic [N-1:0] clkhf, rdy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state per instance: mode 0=off 1=starting 2=running,
    // k = edges since power-up sampled, ph = position within the 2H-edge output period.
    int md[N];
    int k[N];
    int ph[N];

    always #5 clk = ~clk;

    sb_hfosc_if i0 ();
    sb_hfosc_if i1 ();
    sb_hfosc_if i2 ();
    sb_hfosc_if i3 ();
    sb_hfosc_if i4 ();

    assign i0.CLKHFPU = pu; assign i0.CLKHFEN = en;
    assign i1.CLKHFPU = pu; assign i1.CLKHFEN = en;
    assign i2.CLKHFPU = pu; assign i2.CLKHFEN = en;
    assign i3.CLKHFPU = pu; assign i3.CLKHFEN = en;
    assign i4.CLKHFPU = pu; assign i4.CLKHFEN = en;

    assign clkhf = {i4.CLKHF, i3.CLKHF, i2.CLKHF, i1.CLKHF, i0.CLKHF};
    assign rdy   = {i4.CLKHF_RDY, i3.CLKHF_RDY, i2.CLKHF_RDY, i1.CLKHF_RDY, i0.CLKHF_RDY};

    sb_hfosc #(.CLKHF_DIV("0b00"), .STARTUP_CYCLES(SC)) u0 (.clk(clk), .rst(rst), .osc(i0));
    sb_hfosc #(.CLKHF_DIV("0b01"), .STARTUP_CYCLES(SC)) u1 (.clk(clk), .rst(rst), .osc(i1));
    sb_hfosc #(.CLKHF_DIV("0b10"), .STARTUP_CYCLES(SC)) u2 (.clk(clk), .rst(rst), .osc(i2));
    sb_hfosc #(.CLKHF_DIV("0b11"), .STARTUP_CYCLES(SC)) u3 (.clk(clk), .rst(rst), .osc(i3));
    sb_hfosc #(.CLKHF_DIV("0b1x"), .STARTUP_CYCLES(SC)) u4 (.clk(clk), .rst(rst), .osc(i4));

    function automatic int h_of(input int i);
        case (i)
            1:       return 2;
            2:       return 4;
            3:       return 8;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%b want=%b", tag, $time, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            int h;
            h = h_of(i);
            if (rst) begin
                md[i] = 0; k[i] = 0; ph[i] = 0;
            end else if (!pu) begin
                md[i] = 0; k[i] = 0; ph[i] = 0;
            end else if (md[i] == 0) begin
                md[i] = 1; k[i] = 1;
            end else if (md[i] == 1) begin
                k[i]++;
                if (k[i] == SC + 1) begin
                    md[i] = 2; ph[i] = 0;
                end
            end else begin
                if (ph[i] < h && !en) ph[i] = 0;
                else                  ph[i] = (ph[i] + 1) % (2 * h);
            end
        end
    endtask

    task automatic step(input logic r, input logic p, input logic e);
        @(negedge clk);
        rst = r; pu = p; en = e;
        @(posedge clk);
        #1;
        model_edge();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("clkhf%0d", i), clkhf[i], (md[i] == 2) && (ph[i] >= h_of(i)));
            chk($sformatf("rdy%0d", i), rdy[i], md[i] == 2);
        end
    endtask

    initial begin
        int lat;
        logic r, p, e;
        rst = 1'b1; pu = 1'b0; en = 1'b0;
        for (int i = 0; i < N; i++) begin md[i] = 0; k[i] = 0; ph[i] = 0; end

        for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 1'b0);

        // Ready latency from the first edge that samples power-up.
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            step(1'b0, 1'b1, 1'b1);
            if (rdy[0] === 1'b1) begin lat = c; break; end
        end
        n_cmp++;
        if (lat != SC + 1) begin
            n_err++;
            $display("FAIL rdy_lat got=%0d want=%0d", lat, SC + 1);
        end

        for (int c = 0; c < 40; c++) step(1'b0, 1'b1, 1'b1);

        // Random walk over enable, power-up and reset.
        r = 1'b0; p = 1'b1; e = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            r = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 39) == 0) p = ~p;
            if ($urandom_range(0, 9) == 0)  e = ~e;
            step(r, p, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
